// File: rtl/dds_tune_ctrl.sv
// dds_tune_ctrl
//   Key-driven, multi-channel tuning controller for the DDS path.
//   Every raw key is synchronised through two flops and then debounced by its
//   own FSM. Each accepted event steps the frequency or phase word of the
//   selected channel, advances the channel select, or toggles the step direction.
//   Frequency words saturate at [FC_MIN, FC_MAX]. Phase words wrap modulo 2^ACC_W.
//
//   Optional feature: define KEY_AUTOREPEAT_EN to let the key_f and key_p
//   debouncers auto-repeat while the key is held. When the macro is undefined,
//   the repeat counters are not built and each press gives exactly one event.
//
// Ports
//   sclk     in   system clock (the only clock in the block)
//   rst_n    in   asynchronous active-low reset
//   key_f    in   frequency-step key, raw, active-high
//   key_p    in   phase-step key, raw, active-high
//   key_ch   in   channel-select key, raw, active-high
//   key_dir  in   direction-toggle key, raw, active-high
//   fc_word  out  packed frequency words, channel k at [k*ACC_W +: ACC_W]
//   pc_word  out  packed phase words, same packing
//   ch_sel   out  currently selected channel
//   dir_dn   out  step direction (0 = up, 1 = down)
//   upd      out  one-cycle pulse in the first cycle a changed word is visible
//   led0     out  toggles on every accepted phase event
module dds_tune_ctrl #(
  parameter int ACC_W   = 30,
  parameter int CH_N    = 2,
  parameter int FC_INIT = 1074,
  parameter int FC_STEP = 2,
  parameter int PC_STEP = 2,
  parameter int FC_MIN  = 2,
  parameter int FC_MAX  = 2**(ACC_W-1),
  parameter int DEB_CNT = 500000,
  parameter int REP_DLY = 25000000,
  parameter int REP_PER = 5000000
) (
  input  logic                  sclk,
  input  logic                  rst_n,
  input  logic                  key_f,
  input  logic                  key_p,
  input  logic                  key_ch,
  input  logic                  key_dir,
  output logic [CH_N*ACC_W-1:0] fc_word,
  output logic [CH_N*ACC_W-1:0] pc_word,
  output logic [2:0]            ch_sel,
  output logic                  dir_dn,
  output logic                  upd,
  output logic                  led0
);

  localparam int CNT_MAX0 = (DEB_CNT > REP_DLY) ? DEB_CNT : REP_DLY;
  localparam int CNT_MAX  = (CNT_MAX0 > REP_PER) ? CNT_MAX0 : REP_PER;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int XW       = ACC_W + 1;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_DLY_LAST = CNT_W'(REP_DLY - 1);
  localparam logic [CNT_W-1:0] REP_PER_LAST = CNT_W'(REP_PER - 1);
`endif

  localparam logic [XW-1:0]    FMIN_X  = XW'(FC_MIN);
  localparam logic [XW-1:0]    FMAX_X  = XW'(FC_MAX);
  localparam logic [XW-1:0]    FSTEP_X = XW'(FC_STEP);
  localparam logic [ACC_W-1:0] PSTEP   = ACC_W'(PC_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_CHK,
    S_HELD,
    S_REL_CHK
  } deb_state_e;

  // Saturating frequency step. The extra top bit keeps the up-step from overflowing.
  function automatic logic [ACC_W-1:0] fc_sat_step(input logic [ACC_W-1:0] w,
                                                   input logic             dn);
    logic [XW-1:0] wx;
    logic [XW-1:0] res;
    wx = {1'b0, w};
    if (dn) res = (wx < FMIN_X + FSTEP_X) ? FMIN_X : wx - FSTEP_X;
    else    res = (wx + FSTEP_X > FMAX_X) ? FMAX_X : wx + FSTEP_X;
    return res[ACC_W-1:0];
  endfunction

  // Phase step. The word is naturally modulo 2^ACC_W, so it wraps both ways.
  function automatic logic [ACC_W-1:0] pc_wrap_step(input logic [ACC_W-1:0] w,
                                                    input logic             dn);
    return dn ? w - PSTEP : w + PSTEP;
  endfunction

  // ---- stage: two-flop synchroniser, key order {dir, ch, p, f} ----
  logic [3:0] key_raw;
  logic [3:0] key_m_q;
  logic [3:0] key_s_q;
  logic [3:0] evt;

  assign key_raw = {key_dir, key_ch, key_p, key_f};

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      key_m_q <= '0;
      key_s_q <= '0;
    end else begin
      key_m_q <= key_raw;
      key_s_q <= key_m_q;
    end
  end

  // ---- stage: per-key debounce FSMs; evt[k] is a one-cycle accept pulse ----
  for (genvar k = 0; k < 4; k++) begin : g_key
`ifdef KEY_AUTOREPEAT_EN
    localparam bit REP_EN = (k < 2);
`endif
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_d;
`ifdef KEY_AUTOREPEAT_EN
    // rep_q = 0 while waiting for the first repeat, 1 once repeating at REP_PER.
    logic             rep_q, rep_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
`endif

    always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
`ifdef KEY_AUTOREPEAT_EN
        rep_q   <= 1'b0;
        rcnt_q  <= '0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
`ifdef KEY_AUTOREPEAT_EN
        rep_q   <= rep_d;
        rcnt_q  <= rcnt_d;
`endif
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      evt_d   = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_d   = rep_q;
      rcnt_d  = rcnt_q;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (key_s_q[k]) begin
            state_d = S_PRESS_CHK;
            cnt_d   = '0;
          end
        end
        S_PRESS_CHK: begin
          if (!key_s_q[k]) begin
            state_d = S_IDLE;
          end else if (cnt_q == DEB_LAST) begin
            evt_d   = 1'b1;
            state_d = S_HELD;
            cnt_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
            rep_d   = 1'b0;
            rcnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_HELD: begin
          if (!key_s_q[k]) begin
            state_d = S_REL_CHK;
            cnt_d   = '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (REP_EN) begin
            if (rcnt_q == (rep_q ? REP_PER_LAST : REP_DLY_LAST)) begin
              evt_d  = 1'b1;
              rep_d  = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
`endif
        end
        S_REL_CHK: begin
          if (key_s_q[k]) begin
            // A bounce back to HELD restarts the repeat delay from scratch.
            state_d = S_HELD;
`ifdef KEY_AUTOREPEAT_EN
            rep_d   = 1'b0;
            rcnt_d  = '0;
`endif
          end else if (cnt_q == DEB_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    assign evt[k] = evt_d;
  end

  // ---- stage: word / control registers ----
  logic             evt_f, evt_p, evt_ch, evt_dir;
  logic [ACC_W-1:0] fc_q [CH_N];
  logic [ACC_W-1:0] fc_d [CH_N];
  logic [ACC_W-1:0] pc_q [CH_N];
  logic [ACC_W-1:0] pc_d [CH_N];
  logic [ACC_W-1:0] fc_nxt;
  logic [2:0]       ch_q, ch_d;
  logic             dir_q, dir_d;
  logic             upd_q, upd_d;
  logic             led_q, led_d;

  assign evt_f   = evt[0];
  assign evt_p   = evt[1];
  assign evt_ch  = evt[2];
  assign evt_dir = evt[3];

  // Steps use the pre-event ch_q/dir_q. A channel or direction change that
  // arrives in the same cycle takes effect only on the next event.
  always_comb begin
    ch_d   = ch_q;
    dir_d  = dir_q;
    upd_d  = 1'b0;
    led_d  = led_q;
    fc_nxt = '0;
    for (int c = 0; c < CH_N; c++) begin
      fc_d[c] = fc_q[c];
      pc_d[c] = pc_q[c];
      if (ch_q == 3'(c)) begin
        if (evt_f) begin
          fc_nxt  = fc_sat_step(fc_q[c], dir_q);
          fc_d[c] = fc_nxt;
          if (fc_nxt != fc_q[c]) upd_d = 1'b1;
        end
        if (evt_p) begin
          pc_d[c] = pc_wrap_step(pc_q[c], dir_q);
          upd_d   = 1'b1;
        end
      end
    end
    if (evt_p)   led_d = ~led_q;
    if (evt_ch)  ch_d  = (ch_q == 3'(CH_N - 1)) ? 3'd0 : ch_q + 3'd1;
    if (evt_dir) dir_d = ~dir_q;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH_N; c++) begin
        fc_q[c] <= ACC_W'(FC_INIT);
        pc_q[c] <= '0;
      end
      ch_q  <= 3'd0;
      dir_q <= 1'b0;
      upd_q <= 1'b0;
      led_q <= 1'b1;
    end else begin
      for (int c = 0; c < CH_N; c++) begin
        fc_q[c] <= fc_d[c];
        pc_q[c] <= pc_d[c];
      end
      ch_q  <= ch_d;
      dir_q <= dir_d;
      upd_q <= upd_d;
      led_q <= led_d;
    end
  end

  for (genvar c = 0; c < CH_N; c++) begin : g_pack
    assign fc_word[c*ACC_W +: ACC_W] = fc_q[c];
    assign pc_word[c*ACC_W +: ACC_W] = pc_q[c];
  end

  assign ch_sel = ch_q;
  assign dir_dn = dir_q;
  assign upd    = upd_q;
  assign led0   = led_q;

endmodule
